// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: merges NCH SRAM-like request channels onto one memory port.
//
// Handshake: req/addr_ok for the request phase, data_ok for the response phase.
// Up to DEPTH transactions may be in flight. Their channel IDs queue in a FIFO
// so that in-order responses can be routed back to the channel that issued them.
//
// Ports
//   clk, resetn      : clock, synchronous active-low reset
//   ch_req/ch_wr     : per-channel request valid / write flag       [NCH]
//   ch_size          : per-channel size (0 byte, 1 half, 2 word)    [2*NCH]
//   ch_wstrb         : per-channel byte strobes                     [NCH*DW/8]
//   ch_addr/ch_wdata : per-channel address / write data             [NCH*AW]/[NCH*DW]
//   ch_addr_ok       : request accepted (one-hot or zero)           [NCH]
//   ch_data_ok       : response returned (one-hot or zero)          [NCH]
//   ch_rdata         : read data, broadcast to all channels         [DW]
//   mem_*            : shared memory port (req/wr/size/wstrb/addr/wdata out,
//                      addr_ok/data_ok/rdata in)
//   outstanding      : registered in-flight count                   [log2(DEPTH)+1]
//   err_orphan       : sticky; a response arrived with nothing in flight

// One lane per channel. It packs the channel's request fields for the output mux
// and decodes that channel's bit of the addr_ok and data_ok outputs.
module mem_req_arbiter_lane #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int CW   = 1,
  parameter int LANE = 0,
  parameter int PLW  = 1 + 2 + DW/8 + AW + DW
) (
  input  logic            wr,
  input  logic [1:0]      size,
  input  logic [DW/8-1:0] wstrb,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  input  logic [CW-1:0]   grant,
  input  logic [CW-1:0]   head,
  input  logic            accept,
  input  logic            pop,
  output logic            addr_ok,
  output logic            data_ok,
  output logic [PLW-1:0]  pl
);
  assign pl      = {wr, size, wstrb, addr, wdata};
  assign addr_ok = accept && (grant == CW'(LANE));
  assign data_ok = pop && (head == CW'(LANE));
endmodule

module mem_req_arbiter #(
  parameter int NCH   = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NCH-1:0]            ch_req,
  input  logic [NCH-1:0]            ch_wr,
  input  logic [2*NCH-1:0]          ch_size,
  input  logic [NCH*(DW/8)-1:0]     ch_wstrb,
  input  logic [NCH*AW-1:0]         ch_addr,
  input  logic [NCH*DW-1:0]         ch_wdata,
  output logic [NCH-1:0]            ch_addr_ok,
  output logic [NCH-1:0]            ch_data_ok,
  output logic [DW-1:0]             ch_rdata,
  output logic                      mem_req,
  output logic                      mem_wr,
  output logic [1:0]                mem_size,
  output logic [DW/8-1:0]           mem_wstrb,
  output logic [AW-1:0]             mem_addr,
  output logic [DW-1:0]             mem_wdata,
  input  logic                      mem_addr_ok,
  input  logic                      mem_data_ok,
  input  logic [DW-1:0]             mem_rdata,
  output logic [$clog2(DEPTH):0]    outstanding,
  output logic                      err_orphan
);
  localparam int SW  = DW/8;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int PLW = 1 + 2 + SW + AW + DW;

  logic [NCH-1:0][PLW-1:0] ch_pl;
  logic [PLW-1:0]          sel_pl;
  logic [DEPTH-1:0][CW-1:0] id_fifo;
  logic [PW-1:0]           wptr, rptr;
  logic [PW:0]             count;
  logic                    lock_valid;
  logic [CW-1:0]           lock_id, rr_last;
  logic [CW-1:0]           cand, hi_idx, lo_idx, grant, head;
  logic                    hi_found, lo_found;
  logic                    req_sel, not_full, accept, pop, orphan;

  // Round-robin: the first requester above rr_last wins. If there is none, the
  // lowest-numbered requester wins, which wraps the scan back through rr_last.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_req[i] && (i > int'(rr_last)) && !hi_found) begin
        hi_found = 1'b1;
        hi_idx   = CW'(i);
      end
      if (ch_req[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = CW'(i);
      end
    end
    cand = hi_found ? hi_idx : lo_idx;
  end

  // A stalled request keeps the port until it is accepted. If the locked channel
  // withdraws, mem_req drops and the lock is released on the next cycle.
  assign grant    = lock_valid ? lock_id : cand;
  assign req_sel  = lock_valid ? ch_req[lock_id] : |ch_req;
  // count is registered, so a pop in the same cycle does not unblock a full FIFO.
  assign not_full = (count != (PW+1)'(DEPTH));
  assign mem_req  = resetn & req_sel & not_full;
  assign accept   = mem_req & mem_addr_ok;

  assign head     = id_fifo[rptr];
  assign pop      = resetn & mem_data_ok & (count != '0);
  assign orphan   = mem_data_ok & (count == '0);

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    mem_req_arbiter_lane #(
      .AW(AW), .DW(DW), .CW(CW), .LANE(g), .PLW(PLW)
    ) u_lane (
      .wr      (ch_wr[g]),
      .size    (ch_size[2*g +: 2]),
      .wstrb   (ch_wstrb[SW*g +: SW]),
      .addr    (ch_addr[AW*g +: AW]),
      .wdata   (ch_wdata[DW*g +: DW]),
      .grant   (grant),
      .head    (head),
      .accept  (accept),
      .pop     (pop),
      .addr_ok (ch_addr_ok[g]),
      .data_ok (ch_data_ok[g]),
      .pl      (ch_pl[g])
    );
  end

  assign sel_pl = ch_pl[grant];
  assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = sel_pl;
  assign ch_rdata    = mem_rdata;
  assign outstanding = count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      id_fifo    <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      lock_valid <= 1'b0;
      lock_id    <= '0;
      rr_last    <= CW'(NCH-1);
      err_orphan <= 1'b0;
    end else begin
      if (accept) begin
        id_fifo[wptr] <= grant;
        wptr          <= wptr + 1'b1;
        rr_last       <= grant;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      lock_valid <= mem_req & ~mem_addr_ok;
      lock_id    <= grant;
      if (orphan) err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;
  localparam int NCH = 2, AW = 32, DW = 32, DEPTH = 4;
  localparam logic [31:0] A0 = 32'h1C00_0000, A1 = 32'h1C00_0100;
  localparam logic [31:0] W0 = 32'h1111_1111, W1 = 32'h2222_2222;

  logic clk, resetn;
  logic [NCH-1:0] ch_req, ch_wr, ch_addr_ok, ch_data_ok;
  logic [2*NCH-1:0] ch_size;
  logic [NCH*4-1:0] ch_wstrb;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [DW-1:0] ch_rdata, mem_wdata, mem_rdata;
  logic mem_req, mem_wr, mem_addr_ok, mem_data_ok, err_orphan;
  logic [1:0] mem_size;
  logic [3:0] mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [2:0] outstanding;

  int n_cmp = 0, n_bad = 0;

  mem_req_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
    .ch_wstrb(ch_wstrb), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .outstanding(outstanding),
    .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst_n; bit [1:0] req, wr; bit mao, mdo; logic [31:0] rdata;
    bit e_req; bit [1:0] e_aok, e_dok; int e_out; bit e_err; int e_g; bit e_wr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit rst_n, bit [1:0] req, bit [1:0] wr, bit mao, bit mdo,
                              logic [31:0] rdata, bit e_req, bit [1:0] e_aok,
                              bit [1:0] e_dok, int e_out, bit e_err, int e_g, bit e_wr);
    vec_t v;
    v.rst_n = rst_n; v.req = req; v.wr = wr; v.mao = mao; v.mdo = mdo; v.rdata = rdata;
    v.e_req = e_req; v.e_aok = e_aok; v.e_dok = e_dok; v.e_out = e_out;
    v.e_err = e_err; v.e_g = e_g; v.e_wr = e_wr;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic apply(vec_t v, int i);
    @(negedge clk);
    resetn = v.rst_n; ch_req = v.req; ch_wr = v.wr;
    mem_addr_ok = v.mao; mem_data_ok = v.mdo; mem_rdata = v.rdata;
    #2;
    chk($sformatf("r%0d mem_req", i), 64'(mem_req), 64'(v.e_req));
    chk($sformatf("r%0d ch_addr_ok", i), 64'(ch_addr_ok), 64'(v.e_aok));
    chk($sformatf("r%0d ch_data_ok", i), 64'(ch_data_ok), 64'(v.e_dok));
    chk($sformatf("r%0d outstanding", i), 64'(outstanding), 64'(v.e_out));
    chk($sformatf("r%0d err_orphan", i), 64'(err_orphan), 64'(v.e_err));
    if (v.e_req) begin
      chk($sformatf("r%0d mem_addr", i), 64'(mem_addr), 64'(v.e_g == 1 ? A1 : A0));
      chk($sformatf("r%0d mem_wdata", i), 64'(mem_wdata), 64'(v.e_g == 1 ? W1 : W0));
      chk($sformatf("r%0d mem_wr", i), 64'(mem_wr), 64'(v.e_wr));
    end
    if (v.e_dok != 2'b00)
      chk($sformatf("r%0d ch_rdata", i), 64'(ch_rdata), 64'(v.rdata));
  endtask

  initial begin
    resetn = 1'b0; ch_req = '0; ch_wr = '0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    mem_rdata = '0; ch_size = 4'b1010; ch_wstrb = 8'hFF;
    ch_addr = {A1, A0}; ch_wdata = {W1, W0};
    repeat (2) @(posedge clk);

    //          rst req   wr    mao mdo rdata          req aok   dok   out err g wr
    vt.push_back(mk(0, 2'b11, 2'b00, 1, 0, 32'h0,        0, 2'b00, 2'b00, 0, 0, 0, 0)); // r0 reset
    vt.push_back(mk(1, 2'b01, 2'b00, 1, 0, 32'h0,        1, 2'b01, 2'b00, 0, 0, 0, 0)); // r1 single read
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 0, 32'h0,        0, 2'b00, 2'b00, 1, 0, 0, 0));
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 1, 32'hDEADBEEF, 0, 2'b00, 2'b01, 1, 0, 0, 0));
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 0, 32'h0,        0, 2'b00, 2'b00, 0, 0, 0, 0));
    vt.push_back(mk(0, 2'b00, 2'b00, 0, 0, 32'h0,        0, 2'b00, 2'b00, 0, 0, 0, 0)); // r5 reset rr
    vt.push_back(mk(1, 2'b11, 2'b00, 1, 0, 32'h0,        1, 2'b01, 2'b00, 0, 0, 0, 0)); // alternation
    vt.push_back(mk(1, 2'b11, 2'b00, 1, 0, 32'h0,        1, 2'b10, 2'b00, 1, 0, 1, 0));
    vt.push_back(mk(1, 2'b11, 2'b00, 1, 0, 32'h0,        1, 2'b01, 2'b00, 2, 0, 0, 0));
    vt.push_back(mk(1, 2'b11, 2'b00, 1, 0, 32'h0,        1, 2'b10, 2'b00, 3, 0, 1, 0));
    vt.push_back(mk(1, 2'b11, 2'b00, 1, 1, 32'hA0A0A0A0, 0, 2'b00, 2'b01, 4, 0, 0, 0)); // r10 full
    vt.push_back(mk(1, 2'b11, 2'b00, 1, 0, 32'h0,        1, 2'b01, 2'b00, 3, 0, 0, 0)); // reissue
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 1, 32'hB1B1B1B1, 0, 2'b00, 2'b10, 4, 0, 0, 0));
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 1, 32'hC2C2C2C2, 0, 2'b00, 2'b01, 3, 0, 0, 0));
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 1, 32'hD3D3D3D3, 0, 2'b00, 2'b10, 2, 0, 0, 0));
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 1, 32'hE4E4E4E4, 0, 2'b00, 2'b01, 1, 0, 0, 0));
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 0, 32'h0,        0, 2'b00, 2'b00, 0, 0, 0, 0));
    vt.push_back(mk(1, 2'b10, 2'b00, 1, 0, 32'h0,        1, 2'b10, 2'b00, 0, 0, 1, 0)); // r17
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 1, 32'h12345678, 0, 2'b00, 2'b10, 1, 0, 0, 0));
    vt.push_back(mk(1, 2'b10, 2'b10, 0, 0, 32'h0,        1, 2'b00, 2'b00, 0, 0, 1, 1)); // r19 stall
    vt.push_back(mk(1, 2'b11, 2'b10, 0, 0, 32'h0,        1, 2'b00, 2'b00, 0, 0, 1, 1));
    vt.push_back(mk(1, 2'b11, 2'b10, 0, 0, 32'h0,        1, 2'b00, 2'b00, 0, 0, 1, 1));
    vt.push_back(mk(1, 2'b11, 2'b10, 1, 0, 32'h0,        1, 2'b10, 2'b00, 0, 0, 1, 1));
    vt.push_back(mk(1, 2'b01, 2'b00, 1, 0, 32'h0,        1, 2'b01, 2'b00, 1, 0, 0, 0));
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 1, 32'h0BAD0001, 0, 2'b00, 2'b10, 2, 0, 0, 0));
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 1, 32'h0BAD0002, 0, 2'b00, 2'b01, 1, 0, 0, 0));
    vt.push_back(mk(1, 2'b10, 2'b00, 0, 0, 32'h0,        1, 2'b00, 2'b00, 0, 0, 1, 0)); // r26 lock
    vt.push_back(mk(1, 2'b01, 2'b00, 1, 0, 32'h0,        0, 2'b00, 2'b00, 0, 0, 0, 0)); // withdraw
    vt.push_back(mk(1, 2'b01, 2'b00, 1, 0, 32'h0,        1, 2'b01, 2'b00, 0, 0, 0, 0));
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 1, 32'h55AA55AA, 0, 2'b00, 2'b01, 1, 0, 0, 0));
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 1, 32'h0,        0, 2'b00, 2'b00, 0, 0, 0, 0)); // r30 orphan
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 0, 32'h0,        0, 2'b00, 2'b00, 0, 1, 0, 0));
    vt.push_back(mk(1, 2'b11, 2'b00, 1, 0, 32'h0,        1, 2'b10, 2'b00, 0, 1, 1, 0)); // r32
    vt.push_back(mk(1, 2'b11, 2'b00, 1, 0, 32'h0,        1, 2'b01, 2'b00, 1, 1, 0, 0));
    vt.push_back(mk(1, 2'b11, 2'b00, 1, 0, 32'h0,        1, 2'b10, 2'b00, 2, 1, 1, 0));
    vt.push_back(mk(0, 2'b11, 2'b00, 1, 1, 32'h0,        0, 2'b00, 2'b00, 3, 1, 0, 0)); // r35 reset
    vt.push_back(mk(1, 2'b11, 2'b00, 1, 0, 32'h0,        1, 2'b01, 2'b00, 0, 0, 0, 0));
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 1, 32'h77777777, 0, 2'b00, 2'b01, 1, 0, 0, 0)); // stale
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 1, 32'h0,        0, 2'b00, 2'b00, 0, 0, 0, 0));
    vt.push_back(mk(1, 2'b00, 2'b00, 0, 0, 32'h0,        0, 2'b00, 2'b00, 0, 1, 0, 0));

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // Byte write on ch1 then a word read on ch0: size/strobe mux follows grant.
    @(negedge clk);
    ch_req = 2'b10; ch_wr = 2'b10; mem_addr_ok = 1'b1; mem_data_ok = 1'b0;
    ch_size = 4'b0010; ch_wstrb = 8'h4F; ch_addr = {32'h1C00_0103, A0};
    #2;
    chk("h1 ch_addr_ok", 64'(ch_addr_ok), 64'(2'b10));
    chk("h1 mem_size", 64'(mem_size), 64'(0));
    chk("h1 mem_wstrb", 64'(mem_wstrb), 64'(4'b0100));
    chk("h1 mem_addr", 64'(mem_addr), 64'(32'h1C00_0103));
    chk("h1 mem_wr", 64'(mem_wr), 64'(1));
    @(negedge clk);
    ch_req = 2'b01; ch_wr = 2'b00;
    #2;
    chk("h2 ch_addr_ok", 64'(ch_addr_ok), 64'(2'b01));
    chk("h2 mem_size", 64'(mem_size), 64'(2));
    chk("h2 mem_wstrb", 64'(mem_wstrb), 64'(4'hF));
    chk("h2 outstanding", 64'(outstanding), 64'(1));
    @(negedge clk);
    ch_req = 2'b00; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE0001;
    #2;
    chk("h3 ch_data_ok", 64'(ch_data_ok), 64'(2'b10));
    chk("h3 outstanding", 64'(outstanding), 64'(2));
    @(negedge clk);
    mem_rdata = 32'hCAFE0002;
    #2;
    chk("h4 ch_data_ok", 64'(ch_data_ok), 64'(2'b01));
    chk("h4 ch_rdata", 64'(ch_rdata), 64'(32'hCAFE0002));
    @(negedge clk);
    mem_data_ok = 1'b0;
    #2;
    chk("h5 outstanding", 64'(outstanding), 64'(0));
    chk("h5 err_orphan sticky", 64'(err_orphan), 64'(1));
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #2;
    chk("h7 err_orphan cleared", 64'(err_orphan), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
